// File: rtl/fpga_ram_ctrl_if.sv
// fpga_ram_ctrl_if: request/response valid-ready channel between a master and the RAM controller.
interface fpga_ram_ctrl_if #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 10
);
    logic                 req_vld;
    logic                 req_rdy;
    logic                 req_wen;
    logic [ADDRWIDTH-1:0] req_addr;
    logic [DATAWIDTH-1:0] req_wdata;
    logic                 rsp_vld;
    logic                 rsp_rdy;
    logic                 rsp_wr;
    logic [DATAWIDTH-1:0] rsp_rdata;

    modport master (
        output req_vld, req_wen, req_addr, req_wdata, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_wr, rsp_rdata
    );

    modport slave (
        input  req_vld, req_wen, req_addr, req_wdata, rsp_rdy,
        output req_rdy, rsp_vld, rsp_wr, rsp_rdata
    );
endinterface

// File: rtl/fpga_ram_ctrl.sv
// fpga_ram_ctrl: drives a single-port sync RAM from a valid/ready channel, buffering read data in a 2-entry FIFO.
// Define FPGA_RAM_CTRL_INIT_EN to zero the whole RAM after reset before accepting requests.
module fpga_ram_ctrl #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst_b,
    fpga_ram_ctrl_if.slave       bus,
    output logic [ADDRWIDTH-1:0] ram_addr,
    output logic [DATAWIDTH-1:0] ram_din,
    output logic                 ram_wen,
    input  logic [DATAWIDTH-1:0] ram_dout,
    output logic                 init_done
);
    logic                 run;
    logic                 accept;
    logic                 pop;
    logic                 push;
    logic                 pending;
    logic                 tag;
    logic                 head;
    logic                 tail;
    logic [1:0]           count;
    logic [2:0]           occ;
    logic [DATAWIDTH:0]   fifo [2];

`ifdef FPGA_RAM_CTRL_INIT_EN
    typedef enum logic {INIT, RUN} state_t;
    state_t               state;
    state_t               state_nx;
    logic [ADDRWIDTH-1:0] cnt;
    logic                 done_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state  <= INIT;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= (state == INIT) ? cnt + 1'b1 : '0;
            done_q <= state == RUN;
        end
    end

    always_comb begin
        state_nx = state;
        ram_addr = '0;
        ram_din  = '0;
        ram_wen  = 1'b0;
        if (state == INIT) begin
            state_nx = (cnt == '1) ? RUN : INIT;
            ram_addr = cnt;
            ram_wen  = rst_b;
        end else if (rst_b) begin
            ram_addr = bus.req_addr;
            ram_din  = bus.req_wdata;
            ram_wen  = accept & bus.req_wen;
        end
    end

    assign run       = state == RUN;
    assign init_done = done_q;
`else
    assign run       = 1'b1;
    assign init_done = 1'b1;
    assign ram_addr  = rst_b ? bus.req_addr : '0;
    assign ram_din   = rst_b ? bus.req_wdata : '0;
    assign ram_wen   = accept & bus.req_wen;
`endif

    // A pop this cycle frees a slot, so rsp_rdy feeds req_rdy combinationally.
    assign occ         = {2'b0, pending} + {1'b0, count};
    assign pop         = bus.rsp_vld & bus.rsp_rdy;
    assign bus.req_rdy = run & rst_b & ((occ < 3'd2) | pop);
    assign accept      = bus.req_vld & bus.req_rdy;
    assign push        = pending;
    assign bus.rsp_vld = count != 2'd0;
    assign {bus.rsp_wr, bus.rsp_rdata} = fifo[head];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pending <= 1'b0;
            tag     <= 1'b0;
            head    <= 1'b0;
            tail    <= 1'b0;
            count   <= 2'd0;
            fifo[0] <= '0;
            fifo[1] <= '0;
        end else begin
            pending <= accept;
            tag     <= accept ? bus.req_wen : tag;
            if (push) fifo[tail] <= {tag, ram_dout};
            tail    <= tail + push;
            head    <= head + pop;
            count   <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule
